// File: rtl/key_event_queue_pkg.sv
// key_event_queue_pkg: shared widths, entry layout, repeat FSM states and key priority encoder
//   KEY_CODE_W   width of a key index
//   ENTRY_W      width of one queued entry {repeat, code}
//   ENT_REPEAT   bit position of the repeat flag inside an entry (code occupies [3:0])
//   rep_state_e  auto-repeat FSM states
//   lowest_set   index of the lowest set bit of a 16-bit vector (0 when none set)
package key_event_queue_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int ENTRY_W    = 5;
    localparam int ENT_REPEAT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    function automatic logic [KEY_CODE_W-1:0] lowest_set(input logic [15:0] v);
        logic [KEY_CODE_W-1:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) idx = KEY_CODE_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// key_event_fifo: synchronous first-word-fall-through FIFO with separate occupancy counter
//   clk, RST  clock, asynchronous active-high reset
//   push/din  write request and data; ignored when full unless a pop happens in the same cycle
//   pop       read request; ignored when empty
//   dout      head entry, forced to 0 while empty
//   empty     no entries stored
//   full      DEPTH entries stored
//   count     entries stored, 0..DEPTH
module key_event_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en, rd_en;

    always_comb begin
        empty = cnt_q == '0;
        full  = cnt_q == CW'(DEPTH);
        rd_en = pop & ~empty;
        // a pop frees the slot the push needs, so a full FIFO still accepts
        wr_en = push & (~full | rd_en);
        mem_d = mem_q;
        if (wr_en) mem_d[wr_q] = din;
        // pointer width equals log2(DEPTH), so natural overflow wraps modulo DEPTH
        wr_d  = wr_q + AW'(wr_en);
        rd_d  = rd_q + AW'(rd_en);
        cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
        dout  = empty ? '0 : mem_q[rd_q];
        count = cnt_q;
    end

    always_ff @(posedge clk)
        mem_q <= mem_d;

    always_ff @(posedge clk or posedge RST)
        if (RST) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: converts debounced key levels into queued press events with valid/ready output
//   clk         clock
//   RST         asynchronous active-high reset
//   key_deb     debounced key levels, bit i high while key i held
//   ev_valid    FIFO head holds an event
//   ev_ready    consumer accepts the head this cycle
//   ev_code     key index of the head event
//   ev_repeat   head event is an auto-repeat
//   overflow    sticky flag: an event was dropped because the FIFO was full
//   fifo_count  entries currently stored
// Build option: define KEY_REPEAT_EN to add auto-repeat of a held key
// (first repeat REPEAT_DELAY cycles after the press, then every REPEAT_RATE cycles).
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int NKEYS        = 16,
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic [NKEYS-1:0]        key_deb,
    output logic                    ev_valid,
    input  logic                    ev_ready,
    output logic [KEY_CODE_W-1:0]   ev_code,
    output logic                    ev_repeat,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    logic [NKEYS-1:0]      key_prev_q, key_prev_d, rise;
    logic [KEY_CODE_W-1:0] fresh_code;
    logic                  fresh, push, pop, full, empty;
    logic                  overflow_q, overflow_d;
    logic [ENTRY_W-1:0]    din, dout;

    // edge detect; only the lowest-index new press survives a multi-key edge
    always_comb begin
        rise       = key_deb & ~key_prev_q;
        key_prev_d = key_deb;
        fresh      = |rise;
        fresh_code = lowest_set(rise);
    end

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY);

    rep_state_e            state_q, state_d;
    logic [RW-1:0]         cnt_q, cnt_d;
    logic [KEY_CODE_W-1:0] track_q, track_d;
    logic                  rep_push;

    // a fresh press always restarts timing and suppresses any repeat due this cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        track_d  = track_q;
        rep_push = 1'b0;
        if (fresh) begin
            state_d = ST_DELAY;
            track_d = fresh_code;
            cnt_d   = RW'(REPEAT_DELAY - 1);
        end else if (state_q != ST_IDLE) begin
            if (!key_deb[track_q]) begin
                state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
                rep_push = 1'b1;
                cnt_d    = RW'(REPEAT_RATE - 1);
                state_d  = ST_REPEAT;
            end else begin
                cnt_d = cnt_q - RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge RST)
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            track_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            track_q <= track_d;
        end

    always_comb begin
        push      = fresh | rep_push;
        din       = rep_push ? {1'b1, track_q} : {1'b0, fresh_code};
        ev_repeat = dout[ENT_REPEAT];
    end
`else
    logic unused_rep_cfg;

    always_comb begin
        push           = fresh;
        din            = {1'b0, fresh_code};
        ev_repeat      = 1'b0;
        unused_rep_cfg = ^{dout[ENT_REPEAT], REPEAT_DELAY[0], REPEAT_RATE[0]};
    end
`endif

    always_comb begin
        pop        = ~empty & ev_ready;
        ev_valid   = ~empty;
        ev_code    = dout[KEY_CODE_W-1:0];
        overflow_d = overflow_q | (push & full & ~pop);
        overflow   = overflow_q;
    end

    // keys held through reset read as already pressed, so they need a release first
    always_ff @(posedge clk or posedge RST)
        if (RST) begin
            key_prev_q <= '1;
            overflow_q <= 1'b0;
        end else begin
            key_prev_q <= key_prev_d;
            overflow_q <= overflow_d;
        end

    key_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .RST   (RST),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: table vectors, hand sequences and randomized run against a queue-based model
module tb_key_event_queue;

    localparam int DEPTH = 4;
    localparam int RD    = 20;
    localparam int RR    = 5;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] key_deb = 16'h0010;
    logic        ev_ready = 1'b0;
    logic        ev_valid, ev_repeat, overflow;
    logic [3:0]  ev_code;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event_queue #(
        .NKEYS        (16),
        .DEPTH        (DEPTH),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .key_deb    (key_deb),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_repeat  (ev_repeat),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    // reference model: queue of {repeat, code}, sticky overflow, previous keys, held-key age
    int          m_q[$];
    logic [15:0] m_prev;
    logic        m_ovf;
    int          m_track;
    int          m_age;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev  = 16'hffff;
        m_ovf   = 1'b0;
        m_track = -1;
        m_age   = 0;
    endtask

    task automatic model_step(input logic [15:0] k, input logic r);
        logic [15:0] rise;
        bit          pop, has_fresh, rep;
        int          code;
        pop       = m_q.size() > 0 && r;
        rise      = k & ~m_prev;
        has_fresh = rise != 0;
        code      = 0;
        for (int b = 15; b >= 0; b--)
            if (rise[b]) code = b;
        rep = 0;
`ifdef KEY_REPEAT_EN
        if (has_fresh) begin
            m_track = code;
            m_age   = 0;
        end else if (m_track >= 0) begin
            if (!k[m_track]) m_track = -1;
            else begin
                m_age++;
                if (m_age >= RD && (m_age - RD) % RR == 0) rep = 1;
            end
        end
`endif
        if (pop) void'(m_q.pop_front());
        if (has_fresh || rep) begin
            if (m_q.size() < DEPTH) m_q.push_back(has_fresh ? code : 16 + m_track);
            else m_ovf = 1'b1;
        end
        m_prev = k;
    endtask

    task automatic model_check();
        int h;
        h = m_q.size() > 0 ? m_q[0] : 0;
        chk("m_valid", 32'(ev_valid), 32'(m_q.size() > 0));
        chk("m_code", 32'(ev_code), 32'(h[3:0]));
        chk("m_repeat", 32'(ev_repeat), 32'(h[4]));
        chk("m_count", 32'(fifo_count), 32'(m_q.size()));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic cyc(input logic [15:0] k, input logic r);
        @(negedge clk);
        key_deb  = k;
        ev_ready = r;
        model_step(k, r);
        @(posedge clk);
        #1;
        model_check();
    endtask

    typedef struct {
        logic [15:0] k;
        logic        r;
        logic        v;
        logic [3:0]  c;
        logic [2:0]  n;
        logic        o;
    } vec_t;

    vec_t tbl[23];

    initial begin
        logic [15:0] k;
        logic [63:0] rep_mask;
        int          n_fresh;

        tbl[0]  = '{16'h0010, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[1]  = '{16'h0000, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[2]  = '{16'h0010, 1'b0, 1'b1, 4'd4, 3'd1, 1'b0};
        tbl[3]  = '{16'h0010, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[4]  = '{16'h0000, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[5]  = '{16'h0204, 1'b0, 1'b1, 4'd2, 3'd1, 1'b0};
        tbl[6]  = '{16'h0000, 1'b1, 1'b0, 4'd0, 3'd0, 1'b0};
        tbl[7]  = '{16'h0002, 1'b0, 1'b1, 4'd1, 3'd1, 1'b0};
        tbl[8]  = '{16'h0000, 1'b0, 1'b1, 4'd1, 3'd1, 1'b0};
        tbl[9]  = '{16'h0004, 1'b0, 1'b1, 4'd1, 3'd2, 1'b0};
        tbl[10] = '{16'h0000, 1'b0, 1'b1, 4'd1, 3'd2, 1'b0};
        tbl[11] = '{16'h0008, 1'b0, 1'b1, 4'd1, 3'd3, 1'b0};
        tbl[12] = '{16'h0000, 1'b0, 1'b1, 4'd1, 3'd3, 1'b0};
        tbl[13] = '{16'h0010, 1'b0, 1'b1, 4'd1, 3'd4, 1'b0};
        tbl[14] = '{16'h0000, 1'b0, 1'b1, 4'd1, 3'd4, 1'b0};
        tbl[15] = '{16'h0020, 1'b0, 1'b1, 4'd1, 3'd4, 1'b1};
        tbl[16] = '{16'h0000, 1'b0, 1'b1, 4'd1, 3'd4, 1'b1};
        tbl[17] = '{16'h0080, 1'b1, 1'b1, 4'd2, 3'd4, 1'b1};
        tbl[18] = '{16'h0000, 1'b1, 1'b1, 4'd3, 3'd3, 1'b1};
        tbl[19] = '{16'h0000, 1'b1, 1'b1, 4'd4, 3'd2, 1'b1};
        tbl[20] = '{16'h0000, 1'b1, 1'b1, 4'd7, 3'd1, 1'b1};
        tbl[21] = '{16'h0000, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1};
        tbl[22] = '{16'h0000, 1'b1, 1'b0, 4'd0, 3'd0, 1'b1};

        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_code", 32'(ev_code), 32'd0);
        chk("rst_repeat", 32'(ev_repeat), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        @(negedge clk);
        RST = 1'b0;

        for (int i = 0; i < 23; i++) begin
            cyc(tbl[i].k, tbl[i].r);
            chk($sformatf("tbl%0d_valid", i), 32'(ev_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_code", i), 32'(ev_code), 32'(tbl[i].c));
            chk($sformatf("tbl%0d_repeat", i), 32'(ev_repeat), 32'd0);
            chk($sformatf("tbl%0d_count", i), 32'(fifo_count), 32'(tbl[i].n));
            chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].o));
        end

        // async reset mid-stream with entries queued and a key held
        cyc(16'h0001, 1'b0);
        cyc(16'h0000, 1'b0);
        cyc(16'h0002, 1'b0);
        cyc(16'h0000, 1'b0);
        for (int i = 0; i < 26; i++) cyc(16'h0100, 1'b0);
        chk("t6_pre_valid", 32'(ev_valid), 32'd1);
        @(posedge clk);
        #3;
        RST = 1'b1;
        #1;
        chk("t6_async_valid", 32'(ev_valid), 32'd0);
        chk("t6_async_count", 32'(fifo_count), 32'd0);
        chk("t6_async_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(negedge clk);
        RST = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(16'h0100, 1'b0);
            chk("t6_held_no_event", 32'(ev_valid), 32'd0);
        end

`ifdef KEY_REPEAT_EN
        cyc(16'h0000, 1'b1);
        rep_mask = '0;
        n_fresh  = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(16'h0400, 1'b1);
            if (ev_valid && ev_code == 4'd10) begin
                if (ev_repeat) rep_mask[i] = 1'b1;
                else n_fresh++;
            end
        end
        for (int i = 40; i < 55; i++) begin
            cyc(16'h0000, 1'b1);
            if (ev_valid) rep_mask[i] = 1'b1;
        end
        chk("t5_fresh_count", 32'(n_fresh), 32'd1);
        chk("t5_repeat_lo", rep_mask[31:0], (32'd1 << 20) | (32'd1 << 25) | (32'd1 << 30));
        chk("t5_repeat_hi", rep_mask[63:32], 32'd1 << 3);
`endif

        k = 16'h0100;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) k ^= 16'd1 << $urandom_range(0, 15);
            cyc(k, $urandom_range(0, 99) < 30);
        end

        @(negedge clk);
        RST = 1'b1;
        model_reset();
        @(negedge clk);
        RST = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) k ^= 16'd1 << $urandom_range(0, 15);
            cyc(k, $urandom_range(0, 99) < 80);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
